// File: rtl/i2c_tgt_pkg.sv
// i2c_tgt_pkg: shared state encoding and protocol constants for the I2C target
package i2c_tgt_pkg;
  typedef enum logic [3:0] {
    IDLE, ADDR, ACK_ADDR, PTR, ACK_PTR, WDATA, ACK_WDATA, RDATA, RACK, WAIT
  } state_t;
  localparam logic [6:0] I2C_GENERAL_CALL = 7'h00;
  localparam int I2C_BYTE_BITS = 8;
endpackage

// File: rtl/i2c_line_filter.sv
// i2c_line_filter: synchronizes a bus line, accepts a level after FILTER_LEN equal samples, flags edges
module i2c_line_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic lvl_o,
  output logic rise_o,
  output logic fall_o
);
  localparam int CW = $clog2(FILTER_LEN + 1);
  logic [1:0] sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic lvl_q, lvl_d, rise_q, rise_d, fall_q, fall_d;
  always_comb begin
    sync_d = {sync_q[0], raw_i};
    cnt_d = '0;
    lvl_d = lvl_q;
    if (sync_q[1] != lvl_q) begin
      if (cnt_q == CW'(FILTER_LEN - 1)) lvl_d = sync_q[1];
      else cnt_d = cnt_q + CW'(1);
    end
    rise_d = lvl_d & ~lvl_q;
    fall_d = ~lvl_d & lvl_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync_q <= '1;
      cnt_q <= '0;
      lvl_q <= 1'b1;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q <= cnt_d;
      lvl_q <= lvl_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  assign lvl_o = lvl_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;
endmodule

// File: rtl/i2c_target_regfile.sv
// i2c_target_regfile: oversampled I2C target with a pointer-addressed, auto-incrementing byte register file
module i2c_target_regfile
  import i2c_tgt_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR = 7'h48,
  parameter int NUM_REGS = 4,
  parameter int FILTER_LEN = 3,
  parameter logic [NUM_REGS*8-1:0] RESET_VAL = '0,
  localparam int PW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  scl_i,
  input  logic                  sda_i,
  output logic                  sda_oe,
  output logic [NUM_REGS*8-1:0] regs_q,
  output logic                  wr_stb,
  output logic [PW-1:0]         wr_idx,
  output logic                  busy
);
  logic scl_lvl, scl_rise, scl_fall, sda_lvl, sda_rise, sda_fall;
  logic start, stop, last, ack_hi, ptr_ok;
  state_t state_q, state_d;
  logic [7:0] shift_q, shift_d, tx_q, tx_d, byte_in, rd_byte;
  logic [3:0] bit_q, bit_d;
  logic [PW-1:0] ptr_q, ptr_d, ptr_inc, wr_idx_q, wr_idx_d;
  logic [NUM_REGS*8-1:0] regs_d;
  logic rw_q, rw_d, oe_q, oe_d, wr_stb_q, wr_stb_d, busy_q, busy_d;

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl (
    .clk(clk), .rst_n(rst_n), .raw_i(scl_i), .lvl_o(scl_lvl), .rise_o(scl_rise), .fall_o(scl_fall)
  );
  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda (
    .clk(clk), .rst_n(rst_n), .raw_i(sda_i), .lvl_o(sda_lvl), .rise_o(sda_rise), .fall_o(sda_fall)
  );

  // an SCL edge in the same cycle masks START/STOP so data transitions are never misread
  assign start = sda_fall & scl_lvl & ~scl_rise & ~scl_fall;
  assign stop = sda_rise & scl_lvl & ~scl_rise & ~scl_fall;
  assign byte_in = {shift_q[6:0], sda_lvl};
  assign rd_byte = regs_q[8*ptr_q +: 8];
  assign ptr_inc = (ptr_q == PW'(NUM_REGS - 1)) ? '0 : ptr_q + PW'(1);
  assign ptr_ok = {24'd0, byte_in} < NUM_REGS;
  assign last = bit_q == 4'(I2C_BYTE_BITS - 1);
  assign ack_hi = bit_q == 4'(I2C_BYTE_BITS);
  assign sda_oe = oe_q;
  assign wr_stb = wr_stb_q;
  assign wr_idx = wr_idx_q;
  assign busy = busy_q;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d = bit_q;
    ptr_d = ptr_q;
    tx_d = tx_q;
    rw_d = rw_q;
    oe_d = oe_q;
    regs_d = regs_q;
    wr_stb_d = 1'b0;
    wr_idx_d = wr_idx_q;
    busy_d = busy_q;
    if (start || stop) begin
      state_d = start ? ADDR : IDLE;
      busy_d = start;
      bit_d = '0;
      oe_d = 1'b0;
    end else if (scl_rise) begin
      shift_d = byte_in;
      bit_d = bit_q + 4'd1;
      case (state_q)
        ADDR: if (last) begin
          rw_d = byte_in[0];
          state_d = (byte_in[7:1] == TARGET_ADDR && byte_in[7:1] != I2C_GENERAL_CALL) ? ACK_ADDR : WAIT;
        end
        PTR: if (last) begin
          state_d = ptr_ok ? ACK_PTR : WAIT;
          ptr_d = ptr_ok ? byte_in[PW-1:0] : ptr_q;
        end
        WDATA: if (last) begin
          regs_d[8*ptr_q +: 8] = byte_in;
          wr_stb_d = 1'b1;
          wr_idx_d = ptr_q;
          ptr_d = ptr_inc;
          state_d = ACK_WDATA;
        end
        RDATA: if (last) state_d = RACK;
        RACK: begin
          state_d = sda_lvl ? WAIT : RACK;
          ptr_d = sda_lvl ? ptr_q : ptr_inc;
        end
        default: ;
      endcase
    end else if (scl_fall) begin
      // ack phases: first fall drives/releases the 9th bit, second fall hands over to the next byte
      case (state_q)
        ACK_ADDR, ACK_PTR, ACK_WDATA: if (ack_hi) oe_d = 1'b1;
        else begin
          bit_d = '0;
          tx_d = rd_byte;
          oe_d = (state_q == ACK_ADDR) && rw_q && !rd_byte[7];
          state_d = (state_q != ACK_ADDR) ? WDATA : rw_q ? RDATA : PTR;
        end
        RDATA: begin
          tx_d = tx_q << 1;
          oe_d = ~tx_q[6];
        end
        RACK: if (ack_hi) oe_d = 1'b0;
        else begin
          bit_d = '0;
          tx_d = rd_byte;
          oe_d = ~rd_byte[7];
          state_d = RDATA;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q <= '0;
      ptr_q <= '0;
      tx_q <= '0;
      rw_q <= 1'b0;
      oe_q <= 1'b0;
      regs_q <= RESET_VAL;
      wr_stb_q <= 1'b0;
      wr_idx_q <= '0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q <= bit_d;
      ptr_q <= ptr_d;
      tx_q <= tx_d;
      rw_q <= rw_d;
      oe_q <= oe_d;
      regs_q <= regs_d;
      wr_stb_q <= wr_stb_d;
      wr_idx_q <= wr_idx_d;
      busy_q <= busy_d;
    end
endmodule

// File: tb/tb_i2c_target_regfile.sv
// tb_i2c_target_regfile: directed I2C master driving the register-file target with table vectors and corner sequences
module tb_i2c_target_regfile;
  localparam int FL = 3;
  localparam int HALF = 12;
  localparam logic [31:0] RV = 32'h44332211;

  typedef struct {
    logic [7:0] addr, ptr, d0, d1;
    int nd;
    logic [3:0] acks;
    int stb;
    logic [1:0] idx0, idx1;
    logic oe;
    logic [31:0] regs;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;
  logic scl_i, sda_i, sda_oe, wr_stb, busy;
  logic [31:0] regs_q;
  logic [1:0] wr_idx;
  int tests = 0;
  int fails = 0;
  int stb_cnt = 0;
  int oe_cnt = 0;
  logic [1:0] idx_log[$];
  vec_t v[5];
  logic a;
  logic [3:0] acks;
  logic [7:0] d;
  int base, s0, o0;

  assign scl_i = scl_m;
  assign sda_i = sda_m & ~sda_oe;

  i2c_target_regfile #(
    .TARGET_ADDR(7'h48), .NUM_REGS(4), .FILTER_LEN(FL), .RESET_VAL(RV)
  ) dut (
    .clk(clk), .rst_n(rst_n), .scl_i(scl_i), .sda_i(sda_i), .sda_oe(sda_oe),
    .regs_q(regs_q), .wr_stb(wr_stb), .wr_idx(wr_idx), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_stb) begin
      stb_cnt++;
      idx_log.push_back(wr_idx);
    end
    if (sda_oe) oe_cnt++;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not reach the end, got timeout, expected finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic start_cond();
    sda_m = 1'b1;
    wait_clk(HALF);
    scl_m = 1'b1;
    wait_clk(HALF);
    sda_m = 1'b0;
    wait_clk(HALF);
    scl_m = 1'b0;
  endtask

  task automatic stop_cond();
    wait_clk(2);
    sda_m = 1'b0;
    wait_clk(HALF - 2);
    scl_m = 1'b1;
    wait_clk(HALF);
    sda_m = 1'b1;
    wait_clk(HALF);
  endtask

  // g injects an (FL-1)-clock SCL pulse while low and an SDA pulse while high
  task automatic send_bit(input logic b, input logic g);
    wait_clk(2);
    sda_m = b;
    if (g) begin
      wait_clk(3);
      scl_m = 1'b1;
      wait_clk(FL - 1);
      scl_m = 1'b0;
      wait_clk(HALF - 5 - (FL - 1));
    end else wait_clk(HALF - 2);
    scl_m = 1'b1;
    if (g) begin
      wait_clk(4);
      sda_m = ~b;
      wait_clk(FL - 1);
      sda_m = b;
      wait_clk(HALF - 4 - (FL - 1));
    end else wait_clk(HALF);
    scl_m = 1'b0;
  endtask

  task automatic clock_bit(output logic r);
    wait_clk(2);
    sda_m = 1'b1;
    wait_clk(HALF - 2);
    scl_m = 1'b1;
    wait_clk(HALF / 2);
    r = sda_i;
    wait_clk(HALF / 2);
    scl_m = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] b, input logic g, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) send_bit(b[i], g && i == 4);
    clock_bit(r);
    ack = ~r;
  endtask

  task automatic read_byte(input logic ack_m, output logic [7:0] dat);
    logic r;
    dat = '0;
    for (int i = 0; i < 8; i++) begin
      clock_bit(r);
      dat = {dat[6:0], r};
    end
    send_bit(~ack_m, 1'b0);
  endtask

  initial begin
    v[0] = '{8'h90, 8'h01, 8'hA5, 8'h3C, 2, 4'b1111, 2, 2'd1, 2'd2, 1'b1, 32'h443CA511};
    v[1] = '{8'h92, 8'h00, 8'hFF, 8'hFF, 1, 4'b0000, 0, 2'd0, 2'd0, 1'b0, 32'h443CA511};
    v[2] = '{8'h90, 8'h07, 8'h55, 8'h00, 1, 4'b1000, 0, 2'd0, 2'd0, 1'b1, 32'h443CA511};
    v[3] = '{8'h00, 8'h00, 8'h66, 8'h00, 1, 4'b0000, 0, 2'd0, 2'd0, 1'b0, 32'h443CA511};
    v[4] = '{8'h90, 8'h03, 8'h77, 8'h88, 2, 4'b1111, 2, 2'd3, 2'd0, 1'b1, 32'h773CA588};
    wait_clk(4);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_wr_stb", wr_stb, 0);
    chk("rst_wr_idx", wr_idx, 0);
    chk("rst_busy", busy, 0);
    chk("rst_regs", regs_q, RV);
    @(negedge clk) rst_n = 1'b1;
    wait_clk(10);

    for (int i = 0; i < 5; i++) begin
      base = idx_log.size();
      s0 = stb_cnt;
      o0 = oe_cnt;
      acks = '0;
      start_cond();
      chk("vec_busy_hi", busy, 1);
      write_byte(v[i].addr, 1'b0, a);
      acks[3] = a;
      if (a) begin
        write_byte(v[i].ptr, 1'b0, a);
        acks[2] = a;
      end
      if (a && v[i].nd > 0) begin
        write_byte(v[i].d0, 1'b0, a);
        acks[1] = a;
      end
      if (a && v[i].nd > 1) begin
        write_byte(v[i].d1, 1'b0, a);
        acks[0] = a;
      end
      stop_cond();
      wait_clk(4);
      chk($sformatf("vec%0d_acks", i), acks, v[i].acks);
      chk($sformatf("vec%0d_stb_cnt", i), stb_cnt - s0, v[i].stb);
      chk($sformatf("vec%0d_regs", i), regs_q, v[i].regs);
      chk($sformatf("vec%0d_oe_seen", i), oe_cnt != o0, v[i].oe);
      chk($sformatf("vec%0d_busy_lo", i), busy, 0);
      if (v[i].stb > 0) chk($sformatf("vec%0d_idx0", i), (idx_log.size() > base) ? idx_log[base] : 2'bxx, v[i].idx0);
      if (v[i].stb > 1) chk($sformatf("vec%0d_idx1", i), (idx_log.size() > base + 1) ? idx_log[base + 1] : 2'bxx, v[i].idx1);
    end

    start_cond();
    write_byte(8'h91, 1'b0, a);
    chk("cur_read_ack", a, 1);
    read_byte(1'b0, d);
    chk("cur_read_data", d, 8'hA5);
    stop_cond();

    s0 = stb_cnt;
    start_cond();
    write_byte(8'h90, 1'b0, a);
    write_byte(8'h07, 1'b0, a);
    chk("bad_ptr_nack", a, 0);
    stop_cond();
    start_cond();
    write_byte(8'h91, 1'b0, a);
    read_byte(1'b0, d);
    chk("bad_ptr_kept", d, 8'hA5);
    stop_cond();
    chk("bad_ptr_no_stb", stb_cnt - s0, 0);

    start_cond();
    write_byte(8'h90, 1'b0, a);
    write_byte(8'h03, 1'b0, a);
    chk("sr_ptr_ack", a, 1);
    start_cond();
    write_byte(8'h91, 1'b0, a);
    chk("sr_addr_ack", a, 1);
    read_byte(1'b1, d);
    chk("sr_rd0", d, 8'h77);
    read_byte(1'b1, d);
    chk("sr_rd1_wrap", d, 8'h88);
    read_byte(1'b0, d);
    chk("sr_rd2", d, 8'hA5);
    wait_clk(8);
    chk("sr_release", sda_oe, 0);
    stop_cond();

    base = idx_log.size();
    s0 = stb_cnt;
    start_cond();
    write_byte(8'h90, 1'b0, a);
    write_byte(8'h02, 1'b0, a);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    start_cond();
    write_byte(8'h90, 1'b0, a);
    chk("abort_readdr_ack", a, 1);
    write_byte(8'h00, 1'b0, a);
    write_byte(8'h5A, 1'b0, a);
    chk("abort_data_ack", a, 1);
    stop_cond();
    chk("abort_stb_cnt", stb_cnt - s0, 1);
    chk("abort_idx", (idx_log.size() > base) ? idx_log[base] : 2'bxx, 0);
    chk("abort_regs", regs_q, 32'h773CA55A);

    s0 = stb_cnt;
    start_cond();
    write_byte(8'h90, 1'b0, a);
    write_byte(8'h01, 1'b0, a);
    write_byte(8'hC3, 1'b1, a);
    chk("glitch_ack", a, 1);
    chk("glitch_busy", busy, 1);
    stop_cond();
    chk("glitch_stb_cnt", stb_cnt - s0, 1);
    chk("glitch_regs", regs_q, 32'h773CC35A);

    start_cond();
    write_byte(8'h91, 1'b0, a);
    wait_clk(8);
    chk("rst_mid_drive", sda_oe, 1);
    @(negedge clk) rst_n = 1'b0;
    #1;
    chk("rst_mid_release", sda_oe, 0);
    scl_m = 1'b1;
    sda_m = 1'b1;
    wait_clk(5);
    chk("rst_mid_regs", regs_q, RV);
    chk("rst_mid_busy", busy, 0);
    @(negedge clk) rst_n = 1'b1;
    wait_clk(10);

    start_cond();
    write_byte(8'h90, 1'b0, a);
    write_byte(8'h00, 1'b0, a);
    write_byte(8'hE7, 1'b0, a);
    chk("post_rst_ack", a, 1);
    stop_cond();
    chk("post_rst_regs", regs_q, 32'h443322E7);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
